// File: rtl/alu_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc_pkg : funct codes, FSM states and op-class helpers for alu_mc |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_mc_pkg;

    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_SUB   = 6'd34;
    localparam logic [5:0] c_FN_AND   = 6'd36;
    localparam logic [5:0] c_FN_OR    = 6'd37;
    localparam logic [5:0] c_FN_NOR   = 6'd39;
    localparam logic [5:0] c_FN_SLT   = 6'd42;
    localparam logic [5:0] c_FN_SLTU  = 6'd43;
    localparam logic [5:0] c_FN_SRL   = 6'd2;
    localparam logic [5:0] c_FN_MULTU = 6'd25;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [5:0] funct, input logic shamt_nz);
        return (funct == c_FN_MULTU) || ((funct == c_FN_SRL) && shamt_nz);
    endfunction

    function automatic logic is_legal(input logic [5:0] funct);
        logic v;
        case (funct)
            c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_NOR,
            c_FN_SLT, c_FN_SLTU, c_FN_SRL, c_FN_MULTU: v = 1'b1;
            default:                                   v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc_if : request/response handshake bundle for alu_mc             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;
    logic [WIDTH-1:0] dataHi;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, dataA, dataB, Signal, shamt, out_ready,
        input  in_ready, out_valid, dataOut, dataHi, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, dataA, dataB, Signal, shamt, out_ready,
        output in_ready, out_valid, dataOut, dataHi, zero, overflow, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc_core : combinational logic/add/compare unit                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_mc_core
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic [5:0]       i_funct,
    output logic      [WIDTH-1:0] o_result,
    output logic                  o_carry,
    output logic                  o_overflow
);
    logic             w_sub;
    logic [WIDTH-1:0] w_bb;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    // Compares share the subtractor so SLT can correct the sign with overflow.
    assign w_sub = (i_funct == c_FN_SUB) || (i_funct == c_FN_SLT) || (i_funct == c_FN_SLTU);
    assign w_bb  = w_sub ? ~i_b : i_b;
    assign {o_carry, w_sum} = {1'b0, i_a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf = (i_a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_funct)
            c_FN_AND:  o_result = i_a & i_b;
            c_FN_OR:   o_result = i_a | i_b;
            c_FN_NOR:  o_result = ~(i_a | i_b);
            c_FN_ADD,
            c_FN_SUB: begin
                o_result   = w_sum;
                o_overflow = w_ovf;
            end
            c_FN_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            c_FN_SLTU: o_result = {{(WIDTH-1){1'b0}}, ~o_carry};
            default:   o_result = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc : multi-cycle ALU with handshake, iterative SRL and MULTU     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_mc_if.slave   bus
);
    localparam int c_CNTW = SHW + 1;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mcand;
    logic [5:0]           r_fn;
    logic [c_CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]     r_dout;
    logic [WIDTH-1:0]     r_dhi;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_ill;

    logic                 w_accept;
    logic                 w_iter;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic [WIDTH-1:0]     w_core_a;
    logic [WIDTH-1:0]     w_core_b;
    logic [5:0]           w_core_fn;
    logic [WIDTH-1:0]     w_core_res;
    logic                 w_core_cout;
    logic                 w_core_ovf;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_iter   = is_iterative(bus.Signal, |bus.shamt);
    assign w_last   = (r_cnt == c_CNTW'(1));

    // While busy the core's adder accumulates the multiplicand into the HI half.
    always_comb begin
        w_core_a  = bus.dataA;
        w_core_b  = bus.dataB;
        w_core_fn = bus.Signal;
        if (r_state == S_BUSY) begin
            w_core_a  = r_prod[2*WIDTH-1:WIDTH];
            w_core_b  = r_mcand;
            w_core_fn = c_FN_ADD;
        end
    end

    alu_mc_core #(.WIDTH(WIDTH)) u_core (
        .i_a        (w_core_a),
        .i_b        (w_core_b),
        .i_funct    (w_core_fn),
        .o_result   (w_core_res),
        .o_carry    (w_core_cout),
        .o_overflow (w_core_ovf)
    );

    always_comb begin
        w_prod_next = r_prod;
        if (r_fn == c_FN_MULTU) begin
            if (r_prod[0])
                w_prod_next = {w_core_cout, w_core_res, r_prod[WIDTH-1:1]};
            else
                w_prod_next = {1'b0, r_prod[2*WIDTH-1:1]};
        end else begin
            w_prod_next = {{WIDTH{1'b0}}, 1'b0, r_prod[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_next = w_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_fn    <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_dhi   <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
            r_fn    <= bus.Signal;
            r_mcand <= bus.dataB;
            r_prod  <= {{WIDTH{1'b0}}, bus.dataA};
            r_cnt   <= (bus.Signal == c_FN_MULTU) ? c_CNTW'(WIDTH) : c_CNTW'(bus.shamt);
            if (!w_iter) begin
                r_dhi <= '0;
                r_ovf <= w_core_ovf;
                r_ill <= ~is_legal(bus.Signal);
                if (bus.Signal == c_FN_SRL) begin
                    r_dout <= bus.dataA;
                    r_zero <= (bus.dataA == '0);
                end else begin
                    r_dout <= w_core_res;
                    r_zero <= (w_core_res == '0);
                end
            end
        end else if (r_state == S_BUSY) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt - c_CNTW'(1);
            if (w_last) begin
                r_dout <= w_prod_next[WIDTH-1:0];
                r_dhi  <= (r_fn == c_FN_MULTU) ? w_prod_next[2*WIDTH-1:WIDTH] : '0;
                r_zero <= (w_prod_next[WIDTH-1:0] == '0);
                r_ovf  <= 1'b0;
                r_ill  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.dataOut   = r_dout;
    assign bus.dataHi    = r_dhi;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
    assign bus.illegal   = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_mc : vector table + scoreboard bench for alu_mc               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH);

    logic clk = 1'b0;
    logic reset;

    alu_mc_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    alu_mc #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]     fn;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [SHW-1:0] sh;
        logic [31:0]    eo;
        logic [31:0]    eh;
        logic           ez;
        logic           eov;
        logic           eil;
        int             lat;
        int             hold;
        bit             noisy;
    } vec_t;

    typedef struct {
        logic [31:0] eo;
        logic [31:0] eh;
        logic        ez;
        logic        eov;
        logic        eil;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run(input vec_t v);
        int   lat;
        int   t;
        bit   busy_ok;
        exp_t e;
        exp_t en;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.dataA    = v.a;
        bus.dataB    = v.b;
        bus.Signal   = v.fn;
        bus.shamt    = v.sh;
        en = '{v.eo, v.eh, v.ez, v.eov, v.eil};
        sb.push_back(en);
        @(posedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (v.noisy && !bus.out_valid) begin
                bus.in_valid = 1'b1;
                bus.dataA    = $urandom;
                bus.dataB    = $urandom;
                bus.Signal   = c_FN_ADD;
                bus.shamt    = '0;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
        end while (!bus.out_valid && lat < 200);
        bus.in_valid = 1'b0;
        check("latency", 64'(lat), 64'(v.lat));
        if (v.noisy) check("in_ready_low_busy", {63'd0, busy_ok}, 64'd1);
        e = en;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
        end
        check("dataOut",  {32'd0, bus.dataOut}, {32'd0, e.eo});
        check("dataHi",   {32'd0, bus.dataHi},  {32'd0, e.eh});
        check("zero",     {63'd0, bus.zero},     {63'd0, e.ez});
        check("overflow", {63'd0, bus.overflow}, {63'd0, e.eov});
        check("illegal",  {63'd0, bus.illegal},  {63'd0, e.eil});
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            check("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("hold_dataOut",   {32'd0, bus.dataOut},   {32'd0, e.eo});
            check("hold_overflow",  {63'd0, bus.overflow},  {63'd0, e.eov});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("in_ready_after", {63'd0, bus.in_ready}, 64'd1);
        check("out_valid_after", {63'd0, bus.out_valid}, 64'd0);
        check("dataOut_idle_kept", {32'd0, bus.dataOut}, {32'd0, e.eo});
    endtask

    initial begin
        vec_t radd;
        vecs[0]  = '{c_FN_ADD,   32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1,  5, 1'b0};
        vecs[1]  = '{c_FN_SUB,   32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[2]  = '{c_FN_SLT,   32'h7FFFFFFF, 32'h80000000, 5'd0,  32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[3]  = '{c_FN_SLT,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[4]  = '{c_FN_SLTU,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[5]  = '{c_FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33, 0, 1'b1};
        vecs[6]  = '{c_FN_SRL,   32'h80000000, 32'h00000000, 5'd31, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 32, 0, 1'b1};
        vecs[7]  = '{c_FN_SRL,   32'h12345678, 32'h00000000, 5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[8]  = '{6'b111111,  32'hDEADBEEF, 32'h12345678, 5'd0,  32'h00000000, 32'h0,        1'b1, 1'b0, 1'b1, 1,  0, 1'b0};
        vecs[9]  = '{c_FN_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[10] = '{c_FN_OR,    32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[11] = '{c_FN_SUB,   32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1,  0, 1'b0};
        vecs[12] = '{c_FN_MULTU, 32'h00000003, 32'h00000005, 5'd0,  32'h0000000F, 32'h0,        1'b0, 1'b0, 1'b0, 33, 0, 1'b0};
        vecs[13] = '{c_FN_SRL,   32'h0000FF00, 32'h00000000, 5'd4,  32'h00000FF0, 32'h0,        1'b0, 1'b0, 1'b0, 5,  0, 1'b0};
        vecs[14] = '{c_FN_ADD,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1,  0, 1'b0};
        vecs[15] = '{c_FN_NOR,   32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dataA     = '0;
        bus.dataB     = '0;
        bus.Signal    = '0;
        bus.shamt     = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("rst_dataOut",   {32'd0, bus.dataOut},   64'd0);
        reset = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // Abort a MULTU ten cycles in with an asynchronous reset pulse.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Signal   = c_FN_MULTU;
        bus.dataA    = 32'hFFFFFFFF;
        bus.dataB    = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_reset", {63'd0, bus.in_ready}, 64'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("arst_dataOut",   {32'd0, bus.dataOut},   64'd0);
        check("arst_dataHi",    {32'd0, bus.dataHi},    64'd0);
        check("arst_flags",     {61'd0, bus.zero, bus.overflow, bus.illegal}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        radd = '{c_FN_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0};
        run(radd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU, successor to the 32-bit ripple ALU. It adds a valid/ready handshake, signed-correct SLT, SLTU, NOR, an iterative logical right shift and an iterative unsigned multiply with HI/LO result. It sits between the register-read stage and writeback of the multi-cycle datapath, and stalls the controller through in_ready/out_valid.

Parameters:
WIDTH, 32, operand/result width in bits (min 4).
SHW, $clog2(WIDTH), width of the shift-amount port.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
dataA  input  WIDTH  operand A
dataB  input  WIDTH  operand B
Signal  input  6  MIPS funct code selecting the operation
shamt  input  SHW  shift amount for SRL
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer takes result
dataOut  output  WIDTH  result (LO half for MULTU)
dataHi  output  WIDTH  HI half for MULTU, 0 otherwise
zero  output  1  dataOut == 0
overflow  output  1  signed overflow, ADD/SUB only
illegal  output  1  unsupported funct code

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock.
  - Reset forces state IDLE and out_valid=0.
  - It clears dataOut, dataHi, zero, overflow and illegal to 0, and clears all internal registers.
  - Reset mid-operation aborts the operation; nothing is reported.
- Funct codes: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SLTU=43, NOR=39, SRL=2, MULTU=25.
- in_ready = (state == IDLE), combinational from state.
  - Accept occurs when in_valid && in_ready.
  - On accept, dataA, dataB, Signal and shamt are latched; later input changes are ignored.
  - in_valid while not ready is ignored; no queueing.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
  - Single-cycle ops (AND, OR, ADD, SUB, SLT, SLTU, NOR, illegal): IDLE -> DONE. Results registered at accept; out_valid=1 on the cycle after accept (latency 1).
  - SRL, shamt=0: treated as single-cycle; result = A.
  - SRL, shamt>0: BUSY shifts the working register right by 1 per cycle, zero fill. out_valid asserts shamt+1 cycles after accept.
  - MULTU: BUSY runs WIDTH iterations of shift-add using a 2*WIDTH product register. out_valid asserts WIDTH+1 cycles after accept.
- DONE:
  - out_valid=1; all outputs stable until out_valid && out_ready.
  - The block then returns to IDLE, and in_ready=1 on the next cycle.
  - No accept in the DONE cycle.
- Output values stay at the last result while IDLE; they are not cleared.
- Arithmetic:
  - ADD/SUB results wrap modulo 2^WIDTH.
  - overflow = (sign A == sign B') && (sign result != sign A), where B' = ~B for SUB.
  - SLT = sign(A-B) XOR overflow(A-B), so it is correct even when the subtraction overflows.
  - SLTU = !carry_out(A + ~B + 1).
  - SLT/SLTU results are zero-extended 0/1.
- dataHi = 0 for every op except MULTU.
- overflow = 0 for every op except ADD/SUB.
- zero is evaluated on dataOut only.
- Illegal funct: dataOut=0, dataHi=0, illegal=1, latency 1.

Decomposition:
- Package alu_mc_pkg: funct-code constants, FSM state enum (IDLE, BUSY, DONE), op-class helper (single vs iterative).
- Sub-module alu_mc_core: combinational WIDTH-bit logic/add/compare unit producing result, carry_out and overflow. alu_mc reuses its adder for MULTU accumulation.
- FSM, counters, shift and product registers live in alu_mc.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> dataOut 0x80000000, overflow=1, zero=0, out_valid exactly 1 cycle after accept; SUB 5-5 -> 0, zero=1.
- SLT 0x7FFFFFFF vs 0x80000000 -> 0; SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU 0xFFFFFFFF vs 0x00000001 -> 0; overflow=0 for all.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> dataHi 0xFFFFFFFE, dataOut 0x00000001, out_valid 33 cycles after accept; in_ready=0 throughout, and in_valid pulses during BUSY are ignored.
- SRL 0x80000000 shamt=31 -> 0x00000001 after 32 cycles; SRL 0x12345678 shamt=0 -> 0x12345678 after 1 cycle.
- Backpressure: out_ready held low 5 cycles in DONE -> outputs and out_valid stable; after the handshake, in_ready=1 next cycle. Funct 6'b111111 -> illegal=1, dataOut=0.
- Assert reset at cycle 10 of a MULTU -> all outputs 0 immediately (async), FSM IDLE. After release, ADD 3+4 -> 7 with normal latency.
